// File: rtl/input_debounce_sync.sv
// input_debounce_sync: synchronises a raw level and filters bounce with a
// dwell counter. Define DEBOUNCE_TOGGLE_EN to add the push-on/push-off output.
module input_debounce_sync #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned DEBOUNCE_CNT = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
`ifdef DEBOUNCE_TOGGLE_EN
    output logic toggle,
`endif
    output logic busy
);

    // Largest value the dwell counter can hold, computed wide to avoid overflow.
    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $fatal(1, "input_debounce_sync: SYNC_STAGES must be 2..4");
    end

    if (DEBOUNCE_CNT < 1 || longint'(DEBOUNCE_CNT) > CNT_MAX) begin : g_bad_cnt
        $fatal(1, "input_debounce_sync: DEBOUNCE_CNT out of range");
    end

    // Terminal count: the edge at which the candidate level is accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit               ONE_SHOT = (DEBOUNCE_CNT == 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   rise_d;
    logic                   fall_d;
    logic                   dout_d;
    logic                   busy_d;

    // Synchroniser chain: the only consumer of the raw input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // State and dwell counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter update and edge-pulse decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            STABLE_LO: begin
                cnt_d = '0;
                if (s) begin
                    if (ONE_SHOT) begin
                        state_d = STABLE_HI;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = WAIT_HI;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                cnt_d = '0;
                if (!s) begin
                    if (ONE_SHOT) begin
                        state_d = STABLE_LO;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = WAIT_LO;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    // Level and busy flags decoded from the upcoming state.
    always_comb begin
        dout_d = (state_d == STABLE_HI) || (state_d == WAIT_LO);
        busy_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
    end

    // Registered outputs so downstream flops see clean, glitch-free levels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
            busy <= 1'b0;
        end else begin
            dout <= dout_d;
            rise <= rise_d;
            fall <= fall_d;
            busy <= busy_d;
        end
    end

`ifdef DEBOUNCE_TOGGLE_EN
    // Push-on/push-off: flip on each accepted rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            toggle <= 1'b0;
        end else if (rise_d) begin
            toggle <= ~toggle;
        end
    end
`endif

endmodule

// File: doc/input_debounce_sync.md
Name: input_debounce_sync

Overview:
- Conditions a raw asynchronous level, such as a push-button or an off-board strobe, before it is captured by downstream edge-triggered D flip-flops.
- Synchronises the input into the clk domain and filters bounce with a dwell counter.
- Produces a clean level plus single-cycle rise/fall pulses.
- Upstream feeder stage for the team's flip-flop/register elements.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on din; legal range 2..4.
- CNT_W, 16, width of the dwell counter.
- DEBOUNCE_CNT, 16'd50000, consecutive stable samples required to accept a new level; legal range 1..2^CNT_W-1.

Ports:
- clk  input  1  system clock; all state updates on posedge clk.
- rst  input  1  asynchronous reset, active-low (rst==0 resets).
- din  input  1  raw asynchronous input level.
- dout  output  1  debounced level, registered.
- rise  output  1  one-cycle pulse when dout goes 0->1, registered.
- fall  output  1  one-cycle pulse when dout goes 1->0, registered.
- busy  output  1  high while a candidate transition is being timed (WAIT states).

Behaviour:
- Reset (rst==0, asynchronous):
  - sync chain = 0, cnt = 0, state = STABLE_LO.
  - dout = 0, rise = 0, fall = 0, busy = 0.
  - Deassertion takes effect on the next posedge clk.
- Synchroniser: din passes through SYNC_STAGES flops; s = last stage. No other logic reads din directly.
- FSM states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO. dout = 1 in STABLE_HI and WAIT_LO, else 0.
- STABLE_LO:
  - s==1 and DEBOUNCE_CNT==1 -> STABLE_HI, rise=1.
  - s==1 otherwise -> WAIT_HI, cnt<=1.
  - s==0 -> stay, cnt<=0.
- WAIT_HI:
  - s==0 -> STABLE_LO, cnt<=0, no pulse (glitch rejected).
  - s==1 and cnt==DEBOUNCE_CNT-1 -> STABLE_HI, cnt<=0, rise=1.
  - otherwise cnt<=cnt+1.
- STABLE_HI and WAIT_LO mirror STABLE_LO and WAIT_HI with polarity inverted; the transition pulse is fall.
- Acceptance: dout changes on the clk edge at which s has been sampled at the new value on DEBOUNCE_CNT consecutive edges.
- Latency: din change (meeting setup before edge k) -> dout/rise/fall change at edge k+SYNC_STAGES+DEBOUNCE_CNT-1.
- rise/fall:
  - asserted exactly one cycle, coincident with the dout change; never both high.
  - zero in all other cycles.
- busy = 1 exactly in WAIT_HI/WAIT_LO.
- Counter arithmetic:
  - unsigned, CNT_W bits; never exceeds DEBOUNCE_CNT-1, so no wrap.
  - DEBOUNCE_CNT > 2^CNT_W-1 is illegal; simulation fatal via initial check.
- Reset mid-WAIT: candidate discarded; after release, a din held high is re-timed from zero (full latency again).
- Input toggling faster than DEBOUNCE_CNT samples: dout never changes; busy pulses.
- Steady din at reset release: if din==1, dout rises after the full latency, with a rise pulse. There is no reset-time preload.

Optional Feature:
- Macro: DEBOUNCE_TOGGLE_EN.
- When defined:
  - adds output port `toggle` (1 bit, registered, reset 0).
  - toggle inverts on every cycle where rise==1, giving push-on/push-off.
  - toggle is otherwise held.
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CNT=4, CNT_W=4.
- Clean rise: rst released, din 0->1 before edge 10 and held -> dout=1 and rise=1 at edge 15 only; busy high edges 12-14; fall never asserts.
- Glitch rejection: din high for 3 cycles then low -> dout stays 0, rise/fall stay 0, busy high for 3 cycles then 0.
- Clean fall: from dout=1, din 1->0 held -> dout=0 and fall=1 for one cycle, 5 edges after change; rise stays 0.
- Bounce then settle: din toggles 1,0,1,0,1 on successive cycles then holds 1 -> exactly one rise pulse, 5 edges after final settle; no fall.
- Reset mid-operation: assert rst=0 while busy=1 with cnt=2 -> dout, busy, cnt and pulses go 0 immediately (asynchronously). Release with din=1 held -> rise at full latency (5 edges after release).
- DEBOUNCE_TOGGLE_EN defined: three clean press/release cycles -> toggle sequence 1,0,1, each flip coincident with rise; unchanged on fall.
